// File: rtl/rmii_tx_framer.sv
// rmii_tx_framer: RMII transmit sequencer for preamble, payload, pad, FCS and inter-frame gap
module rmii_tx_framer #(
  parameter int MIN_PAYLOAD = 60,
  parameter int IFG_DIBITS  = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [1:0]  txd,
  output logic        tx_en,
  output logic        crc_en,
  output logic [1:0]  crc_data,
  input  logic [31:0] crc_fcs,
  output logic        busy,
  output logic        tx_done,
  output logic        underrun
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG} state_t;
  localparam logic [10:0] MIN_B   = 11'(MIN_PAYLOAD);
  localparam logic [15:0] IFG_END = 16'(IFG_DIBITS - 1);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [10:0] bytes, bytes_n, bytes_inc;
  logic [7:0] sr, sr_n;
  logic [31:0] fcs_sr, fcs_sr_n;
  logic [1:0] txd_n;
  logic last_q, last_n, tx_en_n, crc_en_n, tx_done_n, underrun_n;
  logic byte_end, short_frame, fcs_go;
  assign bytes_inc   = (bytes == 11'h7ff) ? bytes : bytes + 11'd1;
  assign byte_end    = cnt[1:0] == 2'd3;
  assign short_frame = bytes < MIN_B;
  assign busy        = state != IDLE;
  assign crc_data    = txd;
  // next-state and next-output decode; the byte handshake and underrun override the per-state defaults
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 16'd1;
    bytes_n    = bytes;
    sr_n       = sr;
    last_n     = last_q;
    fcs_sr_n   = fcs_sr;
    txd_n      = 2'b00;
    tx_en_n    = 1'b0;
    crc_en_n   = 1'b0;
    tx_done_n  = 1'b0;
    underrun_n = 1'b0;
    s_ready    = 1'b0;
    fcs_go     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        state_n = s_valid ? PREAMBLE : IDLE;
        txd_n   = s_valid ? 2'b01 : 2'b00;
        tx_en_n = s_valid;
      end
      PREAMBLE: begin
        tx_en_n = 1'b1;
        txd_n   = (cnt == 16'd30) ? 2'b11 : 2'b01;
        s_ready = cnt == 16'd31;
      end
      DATA: begin
        tx_en_n  = 1'b1;
        crc_en_n = 1'b1;
        txd_n    = sr[3:2];
        sr_n     = sr >> 2;
        s_ready  = byte_end && !last_q;
        if (byte_end && last_q) begin
          if (short_frame) begin
            state_n = PAD;
            txd_n   = 2'b00;
            cnt_n   = '0;
            bytes_n = bytes_inc;
          end else
            fcs_go = 1'b1;
        end
      end
      PAD: begin
        tx_en_n  = 1'b1;
        crc_en_n = 1'b1;
        if (byte_end) begin
          if (short_frame) begin
            cnt_n   = '0;
            bytes_n = bytes_inc;
          end else
            fcs_go = 1'b1;
        end
      end
      FCS: begin
        tx_en_n   = cnt != 16'd15;
        txd_n     = (cnt == 16'd15) ? 2'b00 : fcs_sr[1:0];
        fcs_sr_n  = fcs_sr >> 2;
        tx_done_n = cnt == 16'd15;
        state_n   = (cnt == 16'd15) ? IFG : FCS;
        cnt_n     = (cnt == 16'd15) ? 16'd0 : cnt + 16'd1;
      end
      IFG: begin
        state_n = (cnt == IFG_END) ? IDLE : IFG;
        cnt_n   = (cnt == IFG_END) ? 16'd0 : cnt + 16'd1;
      end
      default: state_n = IDLE;
    endcase
    if (fcs_go) begin
      state_n  = FCS;
      cnt_n    = '0;
      txd_n    = crc_fcs[1:0];
      fcs_sr_n = crc_fcs >> 2;
      crc_en_n = 1'b0;
    end
    if (s_ready && s_valid) begin
      state_n  = DATA;
      cnt_n    = '0;
      sr_n     = s_data;
      last_n   = s_last;
      txd_n    = s_data[1:0];
      crc_en_n = 1'b1;
      bytes_n  = (state == PREAMBLE) ? 11'd1 : bytes_inc;
    end
    if (s_ready && !s_valid) begin
      state_n    = IFG;
      cnt_n      = '0;
      txd_n      = 2'b00;
      tx_en_n    = 1'b0;
      crc_en_n   = 1'b0;
      underrun_n = 1'b1;
    end
  end
  // state and registered RMII outputs; reset drops tx_en at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bytes    <= '0;
      sr       <= '0;
      last_q   <= 1'b0;
      fcs_sr   <= '0;
      txd      <= 2'b00;
      tx_en    <= 1'b0;
      crc_en   <= 1'b0;
      tx_done  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bytes    <= bytes_n;
      sr       <= sr_n;
      last_q   <= last_n;
      fcs_sr   <= fcs_sr_n;
      txd      <= txd_n;
      tx_en    <= tx_en_n;
      crc_en   <= crc_en_n;
      tx_done  <= tx_done_n;
      underrun <= underrun_n;
    end
  end
endmodule

// File: doc/rmii_tx_framer.md
Name: rmii_tx_framer

Overview:
Transmit-side frame sequencer for the 100 Mb/s RMII MAC, running at the 50 MHz RMII reference clock with one dibit per cycle. It takes a byte stream with valid/ready/last and drives txd/tx_en. Each frame is sent as preamble + SFD, then payload, then zero padding up to the minimum size, then the 32-bit FCS, then the inter-frame gap. It sequences the external crc32 datapath through crc_en, crc_data and crc_fcs.

Parameters:
MIN_PAYLOAD, 60, minimum payload bytes; shorter frames are zero-padded and the padding is included in the CRC. A value of 0 disables padding.
IFG_DIBITS, 48, inter-frame gap in cycles (12 byte times).

Ports:
clk  in  1  RMII 50 MHz reference clock
rst_n  in  1  asynchronous active-low reset
s_data  in  8  payload byte
s_valid  in  1  byte available
s_last  in  1  current byte is the final payload byte
s_ready  out  1  byte accepted this cycle (s_valid & s_ready)
txd  out  2  RMII transmit dibit, registered
tx_en  out  1  RMII transmit enable, registered
crc_en  out  1  to crc32 fcs_en; registered, equals 1 exactly while txd carries a payload/pad dibit
crc_data  out  2  to crc32 data; equals txd
crc_fcs  in  32  from crc32 fcs_out (combinational, complemented remainder)
busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse on the first IFG cycle after a good frame
underrun  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Async reset (rst_n=0): state=IDLE, txd=0, tx_en=0, crc_en=0, s_ready=0, busy=0, tx_done=0, underrun=0, all counters=0.
- Byte serialisation: LSB dibit first. For each byte the order is data[1:0], data[3:2], data[5:4], data[7:6]. One dibit per clock.
- States: IDLE, PREAMBLE, DATA, PAD, FCS, IFG.
- IDLE: s_ready=0. When s_valid is sampled 1, go to PREAMBLE; the first preamble dibit appears on txd/tx_en the next cycle.
- PREAMBLE: 32 cycles. Dibits 0-30 are 2'b01; dibit 31 is 2'b11 (bytes 55×7, D5). s_ready=1 combinationally in the cycle dibit 31 is on txd, loading byte 0 into the shift register. Go to DATA.
- DATA:
  - Shift out 4 dibits per byte. s_ready=1 in the cycle the byte's 4th dibit is on txd, unless the current byte is last.
  - The byte counter (11 bits) increments per byte and saturates at 2047; there is no length limit.
  - If s_ready=1 and s_valid=0: underrun. Next cycle tx_en=0, crc_en=0, underrun pulses, go to IFG. No FCS is sent; tx_done is not pulsed.
  - After the 4th dibit of a last byte: if byte count < MIN_PAYLOAD go to PAD, else go to FCS.
- PAD: send 2'b00 dibits with tx_en=1 and crc_en=1 until the byte count reaches MIN_PAYLOAD, then go to FCS.
- FCS capture: in the cycle the final payload/pad dibit is on txd (crc_en=1), register crc_fcs into fcs_sr. This value includes that dibit.
- FCS: 16 cycles. txd = fcs_sr[1:0], then shift fcs_sr right by 2 each cycle; crc_en=0, tx_en=1. After 16 cycles go to IFG.
- IFG: tx_en=0, txd=0, s_ready=0 for IFG_DIBITS cycles, then go to IDLE. tx_done pulses on the first IFG cycle, only if the FCS was sent.
- crc_en=0 outside DATA/PAD; crc32 therefore re-initialises to FFFF_FFFF between frames.
- s_last is only sampled on an accepted byte. s_data, s_last and s_valid changes while s_ready=0 are ignored.
- Frame length: tx_en is high for exactly 32 + 4·max(N, MIN_PAYLOAD) + 16 cycles; N=0 is not possible, since every frame carries at least one byte.
- Back-to-back frames: s_valid held high during IFG has no effect until IDLE. The minimum frame-to-frame gap is IFG_DIBITS + 1 cycles of tx_en=0.
- Reset mid-frame: tx_en drops immediately (asynchronously), and no partial FCS or pulses are produced.

Test Plan:
1. MIN_PAYLOAD=0; send bytes "123456789" (0x31..0x39), last on 0x39. Required response:
   - tx_en high for 32+36+16 = 84 cycles.
   - The wire FCS bytes decoded LSB-first are 26 39 F4 CB (CRC-32 0xCBF43926).
2. Default parameters; send 10 bytes 0x00..0x09. Required response:
   - 50 pad bytes of 0x00 are transmitted, so tx_en is high for 32+240+16 = 288 cycles.
   - The FCS matches a software CRC-32 over 60 bytes.
   - tx_done pulses once.
3. 100-byte frame; deassert s_valid when s_ready asserts for byte 40. Required response:
   - underrun pulses and tx_en falls the next cycle.
   - No FCS is sent, tx_done stays 0, and tx_en=0 holds for 48 cycles before IDLE.
4. Two 64-byte frames queued with s_valid held high. Required response:
   - Exactly 49 cycles with tx_en=0 between the frames.
   - The preamble reads 01×31 then 11, and both FCS values are correct.
5. Assert rst_n=0 during FCS cycle 5. Required response:
   - All outputs go to 0 immediately.
   - After release, a new 60-byte frame transmits correctly from IDLE.
